// File: rtl/exe_mem_pipe_skid.sv
// EX/MEM pipeline register with valid/ready handshake, one-entry skid buffer, flush and forwarding tap.
// Optional stall counter output enabled by defining EXMEM_STALL_CNT_EN.
module exe_mem_pipe_skid #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef EXMEM_STALL_CNT_EN
    output logic [CNT_W-1:0]   stall_cnt_o,
`endif
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    src2_data_i,
    input  logic [XLEN-1:0]    exe_data_i,
    input  logic               reg_wen_n_i,
    input  logic               dm_enable_n_i,
    input  logic               dm_wen_n_i,
    input  logic               wb_mux_sel_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    src2_data_o,
    output logic [XLEN-1:0]    exe_data_o,
    output logic               reg_wen_n_o,
    output logic               dm_enable_n_o,
    output logic               dm_wen_n_o,
    output logic               wb_mux_sel_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               fwd_valid_o,
    output logic [RADDR_W-1:0] fwd_rd_addr_o,
    output logic [XLEN-1:0]    fwd_data_o
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [XLEN-1:0]    src2;
        logic [XLEN-1:0]    exe;
        logic               reg_wen_n;
        logic               dm_enable_n;
        logic               dm_wen_n;
        logic               wb_mux_sel;
        logic [RADDR_W-1:0] rd_addr;
    } beat_t;

    localparam beat_t BUBBLE = '{src2: '0, exe: '0, reg_wen_n: 1'b1, dm_enable_n: 1'b1,
                                 dm_wen_n: 1'b1, wb_mux_sel: 1'b0, rd_addr: '0};

    state_t state_q, state_d;
    beat_t  main_q, main_d, skid_q, skid_d, in_beat;
    logic   in_ready_q, out_valid_q;
    logic   accept, drain;

    assign in_beat = '{src2: src2_data_i, exe: exe_data_i, reg_wen_n: reg_wen_n_i,
                       dm_enable_n: dm_enable_n_i, dm_wen_n: dm_wen_n_i,
                       wb_mux_sel: wb_mux_sel_i, rd_addr: rd_addr_i};

    assign accept = in_valid_i & in_ready_q & ~flush_i;
    assign drain  = out_valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_beat;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_beat;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_beat;
                    end else if (drain) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Handshake flags are registered from the next state so out_ready_i never reaches in_ready_o combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

`ifdef EXMEM_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign src2_data_o   = main_q.src2;
    assign exe_data_o    = main_q.exe;
    assign reg_wen_n_o   = main_q.reg_wen_n;
    assign dm_enable_n_o = main_q.dm_enable_n;
    assign dm_wen_n_o    = main_q.dm_wen_n;
    assign wb_mux_sel_o  = main_q.wb_mux_sel;
    assign rd_addr_o     = main_q.rd_addr;

    // Only the main register is forwarded; the skid entry is not yet visible to the MEM stage.
    assign fwd_valid_o   = out_valid_q & ~main_q.reg_wen_n & (main_q.rd_addr != '0);
    assign fwd_rd_addr_o = main_q.rd_addr;
    assign fwd_data_o    = main_q.exe;

endmodule

// File: tb/tb_exe_mem_pipe_skid.sv
// Directed self-checking bench for exe_mem_pipe_skid.
// Define EXMEM_STALL_CNT_EN for both files to exercise the stall counter.
module tb_exe_mem_pipe_skid;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst_n;
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [XLEN-1:0]    src2_data_i, exe_data_i;
    logic               reg_wen_n_i, dm_enable_n_i, dm_wen_n_i, wb_mux_sel_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [XLEN-1:0]    src2_data_o, exe_data_o;
    logic               reg_wen_n_o, dm_enable_n_o, dm_wen_n_o, wb_mux_sel_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic               fwd_valid_o;
    logic [RADDR_W-1:0] fwd_rd_addr_o;
    logic [XLEN-1:0]    fwd_data_o;
`ifdef EXMEM_STALL_CNT_EN
    logic [CNT_W-1:0]   stall_cnt_o;
`endif

    int assertCount = 0;
    int failCount   = 0;

    exe_mem_pipe_skid #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef EXMEM_STALL_CNT_EN
        .stall_cnt_o   (stall_cnt_o),
`endif
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .src2_data_i   (src2_data_i),
        .exe_data_i    (exe_data_i),
        .reg_wen_n_i   (reg_wen_n_i),
        .dm_enable_n_i (dm_enable_n_i),
        .dm_wen_n_i    (dm_wen_n_i),
        .wb_mux_sel_i  (wb_mux_sel_i),
        .rd_addr_i     (rd_addr_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .src2_data_o   (src2_data_o),
        .exe_data_o    (exe_data_o),
        .reg_wen_n_o   (reg_wen_n_o),
        .dm_enable_n_o (dm_enable_n_o),
        .dm_wen_n_o    (dm_wen_n_o),
        .wb_mux_sel_o  (wb_mux_sel_o),
        .rd_addr_o     (rd_addr_o),
        .fwd_valid_o   (fwd_valid_o),
        .fwd_rd_addr_o (fwd_rd_addr_o),
        .fwd_data_o    (fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [XLEN-1:0] src2, input logic [XLEN-1:0] exe,
                                 input logic regWenN, input logic dmEnN, input logic dmWenN,
                                 input logic wbSel, input logic [RADDR_W-1:0] rd);
        in_valid_i    = valid;
        src2_data_i   = src2;
        exe_data_i    = exe;
        reg_wen_n_i   = regWenN;
        dm_enable_n_i = dmEnN;
        dm_wen_n_i    = dmWenN;
        wb_mux_sel_i  = wbSel;
        rd_addr_i     = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        checkOutput({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        checkOutput({tag, "_regwen"}, 64'(reg_wen_n_o), 64'd1);
        checkOutput({tag, "_dmen"}, 64'(dm_enable_n_o), 64'd1);
        checkOutput({tag, "_rd"}, 64'(rd_addr_o), 64'd0);
        checkOutput({tag, "_fwd"}, 64'(fwd_valid_o), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        #12;
        checkBubble("rst");
        checkOutput("rst_exe", 64'(exe_data_o), 64'd0);
        checkOutput("rst_dmwen", 64'(dm_wen_n_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat through an empty stage
        out_ready_i = 1'b1;
        applyStimulus(1'b1, 32'hBEEF, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        checkOutput("one_valid", 64'(out_valid_o), 64'd1);
        checkOutput("one_exe", 64'(exe_data_o), 64'h1234);
        checkOutput("one_src2", 64'(src2_data_o), 64'hBEEF);
        checkOutput("one_dmwen", 64'(dm_wen_n_o), 64'd0);
        checkOutput("one_wbsel", 64'(wb_mux_sel_o), 64'd1);
        checkOutput("one_fwdv", 64'(fwd_valid_o), 64'd1);
        checkOutput("one_fwdrd", 64'(fwd_rd_addr_o), 64'd5);
        checkOutput("one_fwdd", 64'(fwd_data_o), 64'h1234);
        tick();
        checkBubble("drain");
        checkOutput("drain_exe", 64'(exe_data_o), 64'd0);

        // A, B, C back to back under back-pressure
        out_ready_i = 1'b0;
        applyStimulus(1'b1, '0, 32'hA, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1);
        tick();
        checkOutput("a_exe", 64'(exe_data_o), 64'hA);
        checkOutput("a_ready", 64'(in_ready_o), 64'd1);
        applyStimulus(1'b1, '0, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2);
        tick();
        checkOutput("b_ready", 64'(in_ready_o), 64'd0);
        checkOutput("b_mainA", 64'(exe_data_o), 64'hA);
        checkOutput("b_fwdrd", 64'(fwd_rd_addr_o), 64'd1);
        applyStimulus(1'b1, '0, 32'hC, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3);
        tick();
        checkOutput("c_hold_exe", 64'(exe_data_o), 64'hA);
        checkOutput("c_hold_ready", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        tick();
        checkOutput("ord_B", 64'(exe_data_o), 64'hB);
        checkOutput("ord_B_rd", 64'(rd_addr_o), 64'd2);
        checkOutput("ord_B_ready", 64'(in_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        checkOutput("ord_C", 64'(exe_data_o), 64'hC);
        checkOutput("ord_C_valid", 64'(out_valid_o), 64'd1);
        tick();
        checkOutput("ord_end_valid", 64'(out_valid_o), 64'd0);

        // Flush while full, with a beat offered in the same cycle
        out_ready_i = 1'b0;
        applyStimulus(1'b1, '0, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
        tick();
        applyStimulus(1'b1, '0, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
        tick();
        checkOutput("pre_flush_ready", 64'(in_ready_o), 64'd0);
        flush_i = 1'b1;
        applyStimulus(1'b1, '0, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9);
        tick();
        flush_i = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        checkBubble("flush");
        out_ready_i = 1'b1;
        tick();
        checkOutput("flush_nostale", 64'(out_valid_o), 64'd0);

        // rd 0 never forwards
        applyStimulus(1'b1, '0, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        checkOutput("rd0_valid", 64'(out_valid_o), 64'd1);
        checkOutput("rd0_fwd", 64'(fwd_valid_o), 64'd0);
        tick();

        // Asynchronous reset in TWO
        out_ready_i = 1'b0;
        applyStimulus(1'b1, '0, 32'h66, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4);
        tick();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        checkOutput("pre_rst_ready", 64'(in_ready_o), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkBubble("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", 64'(out_valid_o), 64'd0);

`ifdef EXMEM_STALL_CNT_EN
        checkOutput("cnt_reset", 64'(stall_cnt_o), 64'd0);
        applyStimulus(1'b1, '0, 32'h77, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        checkOutput("cnt_start", 64'(stall_cnt_o), 64'd0);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("cnt_seven", 64'(stall_cnt_o), 64'd7);
        checkOutput("cnt_hold_exe", 64'(exe_data_o), 64'h77);
        out_ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checkOutput("cnt_after_flush", 64'(stall_cnt_o), 64'd7);
        tick();
        checkOutput("cnt_idle", 64'(stall_cnt_o), 64'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/exe_mem_pipe_skid.md
Name: exe_mem_pipe_skid

Overview:
- Parametrised EX/MEM pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a forwarding tap.
- Sits between the execute stage and the data-memory/write-back stage.
- Inserts NOP bubbles on flush and whenever the stage is empty, so downstream logic that ignores valid still sees a harmless instruction.
- Adds stall and back-pressure support that a plain always-load register lacks.

Parameters:
XLEN, 32, datapath width of src2/exe data
RADDR_W, 5, destination register address width
CNT_W, 16, stall counter width (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
flush_i  input  1  synchronous flush, highest priority
in_valid_i  input  1  EX beat valid
in_ready_o  output  1  stage can accept a beat (registered)
src2_data_i  input  XLEN  store data
exe_data_i  input  XLEN  ALU result / address
reg_wen_n_i  input  1  register write enable, active-low
dm_enable_n_i  input  1  data-memory enable, active-low
dm_wen_n_i  input  1  data-memory write enable, active-low
wb_mux_sel_i  input  1  write-back mux select
rd_addr_i  input  RADDR_W  destination register
out_valid_o  output  1  MEM beat valid
out_ready_i  input  1  downstream accepts
src2_data_o, exe_data_o, reg_wen_n_o, dm_enable_n_o, dm_wen_n_o, wb_mux_sel_o, rd_addr_o  output  as inputs  registered beat
fwd_valid_o  output  1  out_valid_o & ~reg_wen_n_o & (rd_addr_o != 0)
fwd_rd_addr_o  output  RADDR_W  equals rd_addr_o
fwd_data_o  output  XLEN  equals exe_data_o

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Handshake definitions:
  - accept = in_valid_i & in_ready_o & ~flush_i
  - drain = out_valid_o & out_ready_i
- Bubble value: data fields 0; reg_wen_n=1, dm_enable_n=1, dm_wen_n=1, wb_mux_sel=0, rd_addr=0.
- Reset (rst_n=0, immediate):
  - state EMPTY.
  - Main and skid registers hold the bubble value.
  - out_valid_o=0, in_ready_o=1.
- State machine: EMPTY (main bubble), ONE (main valid, skid empty), TWO (main and skid valid).
  - EMPTY: accept -> ONE, main<=input. Otherwise stay.
  - ONE, accept and drain -> ONE, main<=input.
  - ONE, accept only -> TWO, skid<=input.
  - ONE, drain only -> EMPTY, main<=bubble.
  - ONE, neither -> hold.
  - TWO: drain -> ONE, main<=skid, skid<=bubble. Otherwise hold. No accept is possible in TWO.
- in_ready_o is a register:
  - 1 in EMPTY and ONE, 0 in TWO.
  - Updated with the state, so there is no combinational path from out_ready_i to in_ready_o.
- out_valid_o = (state != EMPTY), registered.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY, or was ONE and drained in cycle N.
- Ordering: beats leave strictly in the order they were accepted. No beat is lost or duplicated.
- Flush (flush_i=1 at a clock edge):
  - Next state EMPTY; main and skid <= bubble.
  - A beat presented in the same cycle is dropped, not accepted.
  - A drain in the same cycle still counts as completed downstream.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Forwarding outputs are combinational from the main register only. Skid contents are never forwarded.
- rd_addr 0 never asserts fwd_valid_o.
- rst_n asserted mid-operation: all beats are discarded and the reset values apply immediately.

Optional Feature:
- Macro EXMEM_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [CNT_W-1:0].
  - Increments each cycle with out_valid_o=1 and out_ready_i=0.
  - Saturates at all-ones.
  - Cleared only by rst_n (flush does not clear it).
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then one beat (exe_data=0x1234, rd=5, reg_wen_n=0) with out_ready_i=1 -> out_valid_o=1 next cycle, exe_data_o=0x1234, fwd_valid_o=1, fwd_rd_addr_o=5; returns to EMPTY with bubble outputs after the drain.
- Back-to-back beats A,B,C with out_ready_i=0 -> A in main, B in skid, in_ready_o=0; C held upstream. Raise out_ready_i -> A,B,C emerge in order, one per cycle.
- Stage in TWO, assert flush_i for one cycle -> next cycle out_valid_o=0, in_ready_o=1, reg_wen_n_o=1, dm_enable_n_o=1, rd_addr_o=0; no stale beat emerges.
- Beat with rd_addr=0, reg_wen_n=0 -> out_valid_o=1, fwd_valid_o=0.
- Assert rst_n=0 asynchronously mid-cycle while in TWO -> outputs reach reset values before the next clk edge.
- With EXMEM_STALL_CNT_EN defined: hold out_ready_i=0 for 7 cycles with a valid beat -> stall_cnt_o=7. Flush -> stall_cnt_o stays 7.
